// File: rtl/ab_operand_arbiter.sv
// Two-requester arbiter in front of a shared A/B operand core; a tag FIFO routes each result
// back to the requester that supplied its operands. Define ARB_FIXED_PRIO_EN for fixed priority.
module ab_operand_arbiter #(
   parameter int TAG_DEPTH = 4,
   parameter int TAG_AW    = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        RUN,
   input  logic        STOP,
   output logic        CORE_START,
   output logic        CORE_HALT,
   input  logic        CORE_REQ_AB,
   output logic        CORE_ACK,
   output logic [7:0]  CORE_A,
   output logic [7:0]  CORE_B,
   input  logic [15:0] CORE_X,
   input  logic        CORE_X_VALID,
   input  logic        REQ0,
   input  logic        REQ1,
   input  logic [7:0]  A0,
   input  logic [7:0]  B0,
   input  logic [7:0]  A1,
   input  logic [7:0]  B1,
   output logic        GNT0,
   output logic        GNT1,
   output logic [15:0] X0,
   output logic [15:0] X1,
   output logic        X0_VALID,
   output logic        X1_VALID,
   output logic        TAG_ERR
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      COOL  = 2'd2
   } state_t;

   localparam logic [TAG_AW:0]   DEPTH_C  = (TAG_AW+1)'(TAG_DEPTH);
   localparam logic [TAG_AW:0]   CNT_ZERO = (TAG_AW+1)'(0);
   localparam logic [TAG_AW:0]   CNT_ONE  = (TAG_AW+1)'(1);
   localparam logic [TAG_AW-1:0] PTR_ZERO = TAG_AW'(0);
   localparam logic [TAG_AW-1:0] PTR_ONE  = TAG_AW'(1);

   state_t            state_r;
   logic              tag_mem_r [TAG_DEPTH];
   logic [TAG_AW-1:0] wr_ptr_r;
   logic [TAG_AW-1:0] rd_ptr_r;
   logic [TAG_AW:0]   count_r;
`ifndef ARB_FIXED_PRIO_EN
   logic              last_r;
`endif

   logic winner_s;
   logic fifo_full_s;
   logic fifo_empty_s;
   logic grant_go_s;
   logic push_s;
   logic pop_s;
   logic pop_tag_s;

   // Winner selection for the current request pattern
   always_comb begin
      winner_s = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
      if (REQ0) begin
         winner_s = 1'b0;
      end else begin
         winner_s = REQ1;
      end
`else
      if (REQ0 && REQ1) begin
         winner_s = ~last_r;
      end else begin
         winner_s = REQ1;
      end
`endif
   end

   // Grant qualification and tag FIFO push/pop decisions
   always_comb begin
      fifo_full_s  = (count_r == DEPTH_C);
      fifo_empty_s = (count_r == CNT_ZERO);
      grant_go_s   = (state_r == IDLE) && CORE_REQ_AB && (REQ0 || REQ1)
                     && !fifo_full_s && !STOP;
      push_s       = grant_go_s;
      pop_s        = CORE_X_VALID && (!fifo_empty_s || push_s);
      // An empty FIFO with a same-cycle push pops the entry being pushed
      if (fifo_empty_s) begin
         pop_tag_s = winner_s;
      end else begin
         pop_tag_s = tag_mem_r[rd_ptr_r];
      end
   end

   // Grant sequencer with registered core/requester handshake outputs
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_r    <= IDLE;
         CORE_START <= 1'b0;
         CORE_HALT  <= 1'b0;
         CORE_ACK   <= 1'b0;
         CORE_A     <= 8'h00;
         CORE_B     <= 8'h00;
         GNT0       <= 1'b0;
         GNT1       <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
         last_r     <= 1'b1;
`endif
      end else begin
         CORE_START <= RUN;
         CORE_HALT  <= STOP;
         case (state_r)
            IDLE: begin
               if (grant_go_s) begin
                  state_r  <= GRANT;
                  CORE_ACK <= 1'b1;
                  CORE_A   <= winner_s ? A1 : A0;
                  CORE_B   <= winner_s ? B1 : B0;
                  GNT0     <= ~winner_s;
                  GNT1     <= winner_s;
`ifndef ARB_FIXED_PRIO_EN
                  last_r   <= winner_s;
`endif
               end else begin
                  CORE_ACK <= 1'b0;
                  GNT0     <= 1'b0;
                  GNT1     <= 1'b0;
               end
            end
            GRANT: begin
               state_r  <= COOL;
               CORE_ACK <= 1'b0;
               GNT0     <= 1'b0;
               GNT1     <= 1'b0;
            end
            // One dead cycle so a request still high from the last ACK is not re-served
            COOL: begin
               state_r <= IDLE;
            end
            default: begin
               state_r  <= IDLE;
               CORE_ACK <= 1'b0;
               GNT0     <= 1'b0;
               GNT1     <= 1'b0;
            end
         endcase
      end
   end

   // Tag FIFO storage, pointers and occupancy
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr_r <= PTR_ZERO;
         rd_ptr_r <= PTR_ZERO;
         count_r  <= CNT_ZERO;
         for (int i = 0; i < TAG_DEPTH; i++) begin
            tag_mem_r[i] <= 1'b0;
         end
      end else begin
         if (push_s) begin
            tag_mem_r[wr_ptr_r] <= winner_s;
            wr_ptr_r            <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   // Result routing and sticky orphan-result flag
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         X0       <= 16'h0000;
         X1       <= 16'h0000;
         X0_VALID <= 1'b0;
         X1_VALID <= 1'b0;
         TAG_ERR  <= 1'b0;
      end else begin
         X0_VALID <= pop_s && !pop_tag_s;
         X1_VALID <= pop_s && pop_tag_s;
         if (pop_s && !pop_tag_s) begin
            X0 <= CORE_X;
         end
         if (pop_s && pop_tag_s) begin
            X1 <= CORE_X;
         end
         if (CORE_X_VALID && !pop_s) begin
            TAG_ERR <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ab_operand_arbiter.sv
// Self-checking bench for ab_operand_arbiter: directed scenarios plus random traffic
// compared against a queue-based transaction model.
module tb_ab_operand_arbiter;

   localparam int TAG_DEPTH = 4;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        RUN = 1'b0, STOP = 1'b0;
   logic        CORE_REQ_AB = 1'b0, CORE_X_VALID = 1'b0;
   logic        REQ0 = 1'b0, REQ1 = 1'b0;
   logic [7:0]  A0 = 8'h00, B0 = 8'h00, A1 = 8'h00, B1 = 8'h00;
   logic [15:0] CORE_X = 16'h0000;
   logic        CORE_START, CORE_HALT, CORE_ACK, GNT0, GNT1, X0_VALID, X1_VALID, TAG_ERR;
   logic [7:0]  CORE_A, CORE_B;
   logic [15:0] X0, X1;

   ab_operand_arbiter #(.TAG_DEPTH(TAG_DEPTH), .TAG_AW(2)) dut (
      .CLK(CLK), .RST(RST), .RUN(RUN), .STOP(STOP),
      .CORE_START(CORE_START), .CORE_HALT(CORE_HALT),
      .CORE_REQ_AB(CORE_REQ_AB), .CORE_ACK(CORE_ACK), .CORE_A(CORE_A), .CORE_B(CORE_B),
      .CORE_X(CORE_X), .CORE_X_VALID(CORE_X_VALID),
      .REQ0(REQ0), .REQ1(REQ1), .A0(A0), .B0(B0), .A1(A1), .B1(B1),
      .GNT0(GNT0), .GNT1(GNT1), .X0(X0), .X1(X1),
      .X0_VALID(X0_VALID), .X1_VALID(X1_VALID), .TAG_ERR(TAG_ERR)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_pass   = 0;

   // Transaction-level model: outstanding tags as a queue, grant spacing as a cycle distance
   bit          tags[$];
   bit          m_last;
   int          cyc = 0;
   int          last_grant;
   logic        e_start, e_halt, e_ack, e_g0, e_g1, e_x0v, e_x1v, e_err;
   logic [7:0]  e_a, e_b;
   logic [15:0] e_x0, e_x1;

   function automatic logic [55:0] dut_vec();
      return {CORE_START, CORE_HALT, CORE_ACK, CORE_A, CORE_B, GNT0, GNT1,
              X0, X1, X0_VALID, X1_VALID, TAG_ERR};
   endfunction

   function automatic logic [55:0] exp_vec();
      return {e_start, e_halt, e_ack, e_a, e_b, e_g0, e_g1,
              e_x0, e_x1, e_x0v, e_x1v, e_err};
   endfunction

   task automatic model_reset();
      tags.delete();
      m_last = 1'b1;
      last_grant = -100;
      {e_start, e_halt, e_ack, e_g0, e_g1, e_x0v, e_x1v, e_err} = 8'h00;
      e_a = 8'h00; e_b = 8'h00; e_x0 = 16'h0000; e_x1 = 16'h0000;
   endtask

   // Predict the outcome of the coming clock edge, then advance to just after it
   task automatic tick();
      bit go, w, t;
      go = CORE_REQ_AB && (REQ0 || REQ1) && (tags.size() < TAG_DEPTH) && !STOP
           && (cyc - last_grant >= 3);
`ifdef ARB_FIXED_PRIO_EN
      w = (REQ0 && REQ1) ? 1'b0 : REQ1;
`else
      w = (REQ0 && REQ1) ? !m_last : REQ1;
`endif
      e_ack = go; e_g0 = go && !w; e_g1 = go && w;
      if (go) begin
         e_a = w ? A1 : A0;
         e_b = w ? B1 : B0;
         tags.push_back(w);
         m_last = w;
         last_grant = cyc;
      end
      e_x0v = 1'b0; e_x1v = 1'b0;
      if (CORE_X_VALID) begin
         if (tags.size() > 0) begin
            t = tags.pop_front();
            if (t) begin e_x1 = CORE_X; e_x1v = 1'b1; end
            else   begin e_x0 = CORE_X; e_x0v = 1'b1; end
         end else begin
            e_err = 1'b1;
         end
      end
      e_start = RUN; e_halt = STOP;
      @(posedge CLK);
      #1;
      cyc++;
   endtask

   task automatic idle_inputs();
      CORE_REQ_AB = 1'b0; CORE_X_VALID = 1'b0; REQ0 = 1'b0; REQ1 = 1'b0; STOP = 1'b0;
   endtask

   task automatic apply_reset();
      RST = 1'b1;
      model_reset();
      #1;
      n_checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL reset_state: got %h expected %h", dut_vec(), exp_vec());
      else n_pass++;
      @(posedge CLK);
      #1;
      cyc++;
      RST = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      apply_reset();
   endtask

   task automatic test_single_grant();
      apply_reset();
      RUN = 1'b1; REQ0 = 1'b1; A0 = 8'h4A; B0 = 8'h5B; CORE_REQ_AB = 1'b1;
      tick();
      n_checks++;
      if ({CORE_ACK, GNT0, GNT1, CORE_A, CORE_B, CORE_START} !== {1'b1, 1'b1, 1'b0, 8'h4A, 8'h5B, 1'b1})
         $display("FAIL single_grant: got ack=%b g0=%b g1=%b a=%h b=%h start=%b expected 1 1 0 4a 5b 1",
                  CORE_ACK, GNT0, GNT1, CORE_A, CORE_B, CORE_START);
      else n_pass++;
      CORE_REQ_AB = 1'b0; REQ0 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) begin CORE_X_VALID = 1'b1; CORE_X = 16'($urandom); end
         tick();
         n_checks++;
         if (dut_vec() !== exp_vec()) $display("FAIL single_after: got %h expected %h", dut_vec(), exp_vec());
         else n_pass++;
      end
      CORE_X_VALID = 1'b0;
   endtask

   task automatic test_alternate();
      logic [3:0] seq;
      int nack;
      seq = 4'h0; nack = 0;
      apply_reset();
      REQ0 = 1'b1; REQ1 = 1'b1; A0 = 8'h01; A1 = 8'h02; B0 = 8'($urandom); B1 = 8'($urandom);
      CORE_REQ_AB = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         n_checks++;
         if (dut_vec() !== exp_vec()) $display("FAIL alternate: got %h expected %h", dut_vec(), exp_vec());
         else n_pass++;
         if (CORE_ACK === 1'b1) begin seq = {seq[2:0], GNT1}; nack++; end
      end
      n_checks++;
`ifdef ARB_FIXED_PRIO_EN
      if ({nack[3:0], seq} !== {4'd4, 4'b0000}) $display("FAIL alternate_seq: got n=%0d seq=%b expected 4 0000", nack, seq);
`else
      if ({nack[3:0], seq} !== {4'd4, 4'b0101}) $display("FAIL alternate_seq: got n=%0d seq=%b expected 4 0101", nack, seq);
`endif
      else n_pass++;
      idle_inputs();
      CORE_X_VALID = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i == 4) CORE_X_VALID = 1'b0;
         CORE_X = 16'($urandom);
         tick();
         n_checks++;
         if (dut_vec() !== exp_vec()) $display("FAIL alternate_drain: got %h expected %h", dut_vec(), exp_vec());
         else n_pass++;
      end
   endtask

   task automatic test_routing();
      apply_reset();
      REQ1 = 1'b1; A1 = 8'($urandom); B1 = 8'($urandom); CORE_REQ_AB = 1'b1;
      tick();
      REQ1 = 1'b0; REQ0 = 1'b1; A0 = 8'($urandom); B0 = 8'($urandom);
      tick(); tick(); tick();
      idle_inputs();
      tick();
      CORE_X_VALID = 1'b1; CORE_X = 16'h1A5E;
      tick();
      n_checks++;
      if ({X1, X1_VALID, X0_VALID} !== {16'h1A5E, 1'b1, 1'b0})
         $display("FAIL route_x1: got x1=%h v1=%b v0=%b expected 1a5e 1 0", X1, X1_VALID, X0_VALID);
      else n_pass++;
      CORE_X = 16'h0203;
      tick();
      n_checks++;
      if ({X0, X0_VALID, X1_VALID} !== {16'h0203, 1'b1, 1'b0})
         $display("FAIL route_x0: got x0=%h v0=%b v1=%b expected 0203 1 0", X0, X0_VALID, X1_VALID);
      else n_pass++;
      CORE_X_VALID = 1'b0;
      tick();
      n_checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL route_model: got %h expected %h", dut_vec(), exp_vec());
      else n_pass++;
   endtask

   task automatic test_full();
      int nack;
      nack = 0;
      apply_reset();
      REQ0 = 1'b1; A0 = 8'($urandom); B0 = 8'($urandom); CORE_REQ_AB = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick();
         n_checks++;
         if (dut_vec() !== exp_vec()) $display("FAIL full_fill: got %h expected %h", dut_vec(), exp_vec());
         else n_pass++;
         if (CORE_ACK === 1'b1) nack++;
      end
      n_checks++;
      if (nack != 4) $display("FAIL full_limit: got %0d acks expected 4", nack);
      else n_pass++;
      nack = 0;
      CORE_X_VALID = 1'b1; CORE_X = 16'($urandom);
      for (int i = 0; i < 4; i++) begin
         tick();
         CORE_X_VALID = 1'b0;
         if (CORE_ACK === 1'b1) nack++;
      end
      n_checks++;
      if (nack != 1) $display("FAIL full_release: got %0d acks expected 1", nack);
      else n_pass++;
      idle_inputs();
   endtask

   task automatic test_tag_err();
      apply_reset();
      CORE_X_VALID = 1'b1; CORE_X = 16'($urandom);
      tick();
      n_checks++;
      if ({TAG_ERR, X0_VALID, X1_VALID} !== 3'b100)
         $display("FAIL tag_err_set: got err=%b v0=%b v1=%b expected 1 0 0", TAG_ERR, X0_VALID, X1_VALID);
      else n_pass++;
      CORE_X_VALID = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      n_checks++;
      if (TAG_ERR !== 1'b1) $display("FAIL tag_err_sticky: got %b expected 1", TAG_ERR);
      else n_pass++;
      apply_reset();
   endtask

   task automatic test_stop_and_reset();
      apply_reset();
      STOP = 1'b1; REQ0 = 1'b1; A0 = 8'($urandom); B0 = 8'($urandom); CORE_REQ_AB = 1'b1;
      tick();
      n_checks++;
      if ({CORE_ACK, GNT0, CORE_HALT} !== 3'b001)
         $display("FAIL stop_block: got ack=%b g0=%b halt=%b expected 0 0 1", CORE_ACK, GNT0, CORE_HALT);
      else n_pass++;
      tick();
      STOP = 1'b0;
      tick();
      n_checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL stop_release: got %h expected %h", dut_vec(), exp_vec());
      else n_pass++;
      #2;
      RST = 1'b1;
      model_reset();
      #1;
      n_checks++;
      if ({CORE_ACK, GNT0} !== 2'b00) $display("FAIL reset_mid: got ack=%b g0=%b expected 0 0", CORE_ACK, GNT0);
      else n_pass++;
      @(posedge CLK);
      #1;
      cyc++;
      RST = 1'b0;
      idle_inputs();
      CORE_X_VALID = 1'b1; CORE_X = 16'($urandom);
      tick();
      CORE_X_VALID = 1'b0;
      n_checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL reset_lost_tag: got %h expected %h", dut_vec(), exp_vec());
      else n_pass++;
   endtask

   task automatic test_random();
      apply_reset();
      for (int i = 0; i < 400; i++) begin
         RUN          = ($urandom_range(0, 7) != 0);
         STOP         = ($urandom_range(0, 7) == 0);
         CORE_REQ_AB  = $urandom_range(0, 1) == 1;
         REQ0         = $urandom_range(0, 1) == 1;
         REQ1         = $urandom_range(0, 1) == 1;
         A0 = 8'($urandom); B0 = 8'($urandom); A1 = 8'($urandom); B1 = 8'($urandom);
         CORE_X_VALID = ($urandom_range(0, 3) == 0);
         CORE_X       = 16'($urandom);
         tick();
         n_checks++;
         if (dut_vec() !== exp_vec()) $display("FAIL random[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
         else n_pass++;
      end
      idle_inputs();
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single_grant();
      test_alternate();
      test_routing();
      test_full();
      test_tag_err();
      test_stop_and_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ab_operand_arbiter.md
Name: ab_operand_arbiter

Overview:
- Shares one A/B operand core (REQ_AB/ACK operand handshake, 16-bit X/X_VALID result) between two requesters.
- Arbitrates each operand request from the core, drives the winner's A/B with a one-cycle ACK, and records the winner's ID in a tag FIFO.
- Routes each returning X to the requester that supplied its operands.
- Sits between the requester logic and the core in the top level; also forwards START/HALT.

Parameters:
- TAG_DEPTH, 4: tag FIFO entries, i.e. maximum operand sets in flight (power of two, 2..16).
- TAG_AW, 2: log2(TAG_DEPTH).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- RUN  in  1  top-level run enable.
- STOP  in  1  top-level halt request.
- CORE_START  out  1  start to core.
- CORE_HALT  out  1  halt to core.
- CORE_REQ_AB  in  1  core requests an operand pair.
- CORE_ACK  out  1  operands valid on CORE_A/CORE_B this cycle.
- CORE_A  out  8  operand A to core.
- CORE_B  out  8  operand B to core.
- CORE_X  in  16  core result.
- CORE_X_VALID  in  1  CORE_X valid, one-cycle pulse.
- REQ0, REQ1  in  1 each  requester n has an operand pair.
- A0, B0, A1, B1  in  8 each  requester operands.
- GNT0, GNT1  out  1 each  operands of requester n consumed.
- X0, X1  out  16 each  routed result.
- X0_VALID, X1_VALID  out  1 each  routed result strobe.
- TAG_ERR  out  1  sticky: result arrived with empty tag FIFO.

Behaviour:
- Reset values: CORE_START=0, CORE_HALT=0, CORE_ACK=0, CORE_A=0, CORE_B=0, GNTn=0, Xn=0, Xn_VALID=0, TAG_ERR=0, FSM=IDLE, tag FIFO empty, RR pointer last=1 (requester 0 wins the first tie).
- All outputs are registered.
- CORE_START <= RUN. CORE_HALT <= STOP. One cycle latency each.

FSM states: IDLE, GRANT, COOL.
- IDLE -> GRANT when CORE_REQ_AB=1, (REQ0|REQ1)=1, tag count<TAG_DEPTH and STOP=0.
  - Winner: requester 0 if only REQ0 is set; requester 1 if only REQ1 is set; if both are set, the requester other than last.
  - Registered on the transition: CORE_A/CORE_B <= winner An/Bn, CORE_ACK<=1, GNTwinner<=1, winner ID pushed to tag FIFO, last<=winner.
- GRANT lasts exactly one cycle (CORE_ACK=1, GNTn=1), then -> COOL. CORE_ACK and GNTn clear to 0.
- COOL lasts one cycle; CORE_REQ_AB is ignored so a stale request is not re-served. Then -> IDLE.
- Result: at most one grant per 3 cycles. CORE_A/CORE_B hold their last value outside GRANT.
- Requester rule: An/Bn must be stable while REQn=1. REQn is sampled only in IDLE. After GNTn, keeping REQn high requests another pair.

Result routing:
- CORE_X_VALID=1 with FIFO non-empty: pop the tag. Next cycle XID<=CORE_X and XID_VALID=1 for one cycle; the other requester's strobe is 0.
- CORE_X_VALID=1 with FIFO empty: result dropped, TAG_ERR<=1 (cleared only by RST).
- Push and pop in the same cycle: both performed, count unchanged. Pop uses the pre-push head, so a single entry is valid even when count=0 before the push.
- FIFO full: no grant. The FSM stays in IDLE, and CORE_REQ_AB stays pending until a pop frees an entry.
- FIFO pointers wrap modulo TAG_DEPTH.
- STOP=1: no new grants. An in-progress GRANT/COOL completes. Results are still routed.
- RST asserted mid-operation: all state clears immediately. In-flight tags are lost, and later results set TAG_ERR.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: requester 0 always wins when both REQ0 and REQ1 are set; the last pointer is unused.
- Undefined: round-robin as above.

Test Plan:
- Reset, RUN=1, REQ0=1 A0=0x4A B0=0x5B, core raises REQ_AB -> 1 cycle later CORE_ACK=1, GNT0=1, CORE_A=0x4A, CORE_B=0x5B; CORE_START=1 one cycle after RUN.
- Both requesting (A0=0x01, A1=0x02), REQ_AB held high -> grants alternate 0,1,0,1, spaced 3 cycles apart; with ARB_FIXED_PRIO_EN all grants go to 0.
- Grants to 1 then 0, then core returns X=0x1A5E then X=0x0203 -> X1=0x1A5E with X1_VALID, then X0=0x0203 with X0_VALID, each 1 cycle after CORE_X_VALID.
- 4 grants with no results (TAG_DEPTH=4) -> no 5th ACK while REQ_AB=1; one CORE_X_VALID -> the 5th grant occurs.
- CORE_X_VALID with empty FIFO -> no Xn_VALID, TAG_ERR=1 and stays 1 until RST.
- STOP=1 in IDLE with REQ_AB and REQ0 set -> no ACK, CORE_HALT=1 next cycle; RST during GRANT -> CORE_ACK=0, GNT0=0 immediately.
